// File: rtl/gamma_lut_pkg.sv
// Shared constants and types for the gamma LUT load sequencer.
package gamma_lut_pkg;

    localparam int DATA_WIDTH_DEF = 10;

    localparam logic [1:0] CH_NONE = 2'd0;
    localparam logic [1:0] CH_R    = 2'd1;
    localparam logic [1:0] CH_G    = 2'd2;
    localparam logic [1:0] CH_B    = 2'd3;

    localparam logic MODE_STREAM = 1'b0;
    localparam logic MODE_IDENT  = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT_VB = 2'd1,
        ST_LOAD    = 2'd2,
        ST_DONE    = 2'd3
    } state_e;

    // Lowest set channel whose code is above cur; CH_NONE when none remain.
    // Passing cur = CH_NONE yields the first channel of the mask.
    function automatic logic [1:0] next_code(input logic [2:0] mask, input logic [1:0] cur);
        logic [1:0] res;
        res = CH_NONE;
        for (int i = 2; i >= 0; i--) begin
            if (mask[i] && (2'(i + 1) > cur)) begin
                res = 2'(i + 1);
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/gamma_lut_ctrl.sv
// Loads the R/G/B gamma LUTs through their shared write port, either from a
// host stream or as an identity ramp, starting only inside vertical blanking.
//
// state   | meaning
// IDLE    | waiting for iSTART
// WAIT_VB | load requested, holding off until vertical blanking
// LOAD    | writing entries; walks the masked channels R -> G -> B
// DONE    | load finished; oDONE pulses on the following cycle
module gamma_lut_ctrl
    import gamma_lut_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iSTART,
    input  logic                  iMODE,
    input  logic [2:0]            iCH_MASK,
    input  logic                  iABORT,
    input  logic                  iVBLANK,
    input  logic [DATA_WIDTH-1:0] iS_DATA,
    input  logic                  iS_VALID,
    output logic                  oS_READY,
    output logic [DATA_WIDTH-1:0] oWRDATA,
    output logic [DATA_WIDTH+1:0] oWRADDRESS,
    output logic                  oWRITE,
    output logic                  oBUSY,
    output logic                  oDONE
);

    localparam logic [DATA_WIDTH-1:0] IDX_LAST = '1;

    state_e                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [2:0]            mask_q, mask_d;
    logic [1:0]            code_q, code_d;
    logic [DATA_WIDTH-1:0] idx_q, idx_d;
    logic [DATA_WIDTH-1:0] wrdata_q, wrdata_d;
    logic [DATA_WIDTH+1:0] wraddr_q, wraddr_d;
    logic                  write_q, write_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  wr_en;
    logic [1:0]            code_next;

    assign code_next = next_code(mask_q, code_q);
    assign oS_READY  = (state_q == ST_LOAD) && (mode_q == MODE_STREAM);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        mask_d   = mask_q;
        code_d   = code_q;
        idx_d    = idx_q;
        wr_en    = 1'b0;
        wrdata_d = '0;
        wraddr_d = '0;

        case (state_q)
            ST_IDLE: begin
                if (iSTART) begin
                    mode_d  = iMODE;
                    mask_d  = iCH_MASK;
                    code_d  = next_code(iCH_MASK, CH_NONE);
                    idx_d   = '0;
                    state_d = (iCH_MASK == 3'b000) ? ST_DONE : ST_WAIT_VB;
                end
            end
            ST_WAIT_VB: begin
                if (iABORT) begin
                    state_d = ST_IDLE;
                end else if (iVBLANK) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // Abort wins over the write, the wrap and the channel advance.
                if (iABORT) begin
                    state_d = ST_IDLE;
                end else begin
                    wr_en = (mode_q == MODE_IDENT) || iS_VALID;
                    if (wr_en) begin
                        wraddr_d = {code_q, idx_q};
                        wrdata_d = (mode_q == MODE_IDENT) ? idx_q : iS_DATA;
                        idx_d    = idx_q + 1'b1;
                        if (idx_q == IDX_LAST) begin
                            code_d = code_next;
                            if (code_next == CH_NONE) begin
                                state_d = ST_DONE;
                            end
                        end
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        write_d = wr_en;
        busy_d  = (state_d != ST_IDLE);
        done_d  = (state_q == ST_DONE);
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_STREAM;
            mask_q   <= '0;
            code_q   <= CH_NONE;
            idx_q    <= '0;
            wrdata_q <= '0;
            wraddr_q <= '0;
            write_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            mask_q   <= mask_d;
            code_q   <= code_d;
            idx_q    <= idx_d;
            wrdata_q <= wrdata_d;
            wraddr_q <= wraddr_d;
            write_q  <= write_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign oWRDATA    = wrdata_q;
    assign oWRADDRESS = wraddr_q;
    assign oWRITE     = write_q;
    assign oBUSY      = busy_q;
    assign oDONE      = done_q;

endmodule

// File: tb/tb_gamma_lut_ctrl.sv
// Directed bench for gamma_lut_ctrl: an expected-write queue built from the
// load rules, a LUT image filled from observed writes, and timing pins.
module tb_gamma_lut_ctrl;
    import gamma_lut_pkg::*;

    localparam int DW = 10;
    localparam int N  = 1 << DW;

    logic          iCLK = 1'b0;
    logic          iRST, iSTART, iMODE, iABORT, iVBLANK, iS_VALID;
    logic [2:0]    iCH_MASK;
    logic [DW-1:0] iS_DATA;
    logic          oS_READY, oWRITE, oBUSY, oDONE;
    logic [DW-1:0] oWRDATA;
    logic [DW+1:0] oWRADDRESS;

    gamma_lut_ctrl #(.DATA_WIDTH(DW)) dut (
        .iCLK(iCLK), .iRST(iRST), .iSTART(iSTART), .iMODE(iMODE),
        .iCH_MASK(iCH_MASK), .iABORT(iABORT), .iVBLANK(iVBLANK),
        .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
        .oWRDATA(oWRDATA), .oWRADDRESS(oWRADDRESS), .oWRITE(oWRITE),
        .oBUSY(oBUSY), .oDONE(oDONE)
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [DW+1:0] exp_addr[$];
    logic [DW-1:0] exp_data[$];
    logic [DW-1:0] lut[3][N];
    int  n_writes = 0, first_wr_cyc = 0, last_wr_cyc = 0, n_done = 0, done_cyc = 0;
    bit  mon_en = 0, track_stream = 0, pend = 0;
    logic [1:0]    mcode;
    logic [DW+1:0] ea;
    logic [DW-1:0] ed;

    always @(posedge iCLK) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compare process: every write must be the next one the model predicts.
    always @(negedge iCLK) begin
        if (mon_en) begin
            mcode = oWRADDRESS[DW+1:DW];
            chk("write_vs_code", 32'(oWRITE), 32'(mcode != CH_NONE));
            if (track_stream) begin
                chk("stream_latency", 32'(oWRITE), 32'(pend));
                pend = oS_READY && iS_VALID && !iABORT;
            end
            if (oWRITE) begin
                n_writes++;
                if (n_writes == 1) first_wr_cyc = cyc;
                last_wr_cyc = cyc;
                if (mcode != CH_NONE) lut[int'(mcode) - 1][oWRADDRESS[DW-1:0]] = oWRDATA;
                if (exp_addr.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write (cycle %0d)",
                             oWRADDRESS, oWRDATA, cyc);
                end else begin
                    ea = exp_addr.pop_front();
                    ed = exp_data.pop_front();
                    chk("wr_addr", 32'(oWRADDRESS), 32'(ea));
                    chk("wr_data", 32'(oWRDATA), 32'(ed));
                end
            end
            if (oDONE) begin
                n_done++;
                done_cyc = cyc;
            end
        end
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic clr();
        exp_addr.delete();
        exp_data.delete();
        n_writes = 0;
        n_done   = 0;
    endtask

    task automatic push_ident(input logic [2:0] mask);
        for (int c = 0; c < 3; c++) begin
            if (mask[c]) begin
                for (int i = 0; i < N; i++) begin
                    exp_addr.push_back({2'(c + 1), DW'(i)});
                    exp_data.push_back(DW'(i));
                end
            end
        end
    endtask

    task automatic start_load(input logic mode, input logic [2:0] mask, output int s);
        iMODE    = mode;
        iCH_MASK = mask;
        iSTART   = 1'b1;
        s        = cyc;
        tick();
        iSTART   = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name);
        int d0;
        bit seen;
        d0   = n_done;
        seen = 0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (n_done != d0) seen = 1;
        end
        chk({name, "_done_seen"}, 32'(seen), 1);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_write"}, 32'(oWRITE), 0);
        chk({name, "_addr"},  32'(oWRADDRESS), 0);
        chk({name, "_data"},  32'(oWRDATA), 0);
        chk({name, "_busy"},  32'(oBUSY), 0);
        chk({name, "_done"},  32'(oDONE), 0);
        chk({name, "_ready"}, 32'(oS_READY), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, vb, k, guard;
        logic [DW+1:0] target;

        iRST = 1; iSTART = 0; iMODE = 0; iCH_MASK = 0; iABORT = 0;
        iVBLANK = 1; iS_DATA = 0; iS_VALID = 0;

        // Reset state
        repeat (3) tick();
        chk_all_zero("reset");
        iRST   = 0;
        mon_en = 1;
        tick();

        // Empty mask: DONE immediately, pulse two cycles after start; a
        // second start while busy is ignored.
        clr();
        start_load(MODE_IDENT, 3'b000, s);
        chk("m0_busy", 32'(oBUSY), 1);
        chk("m0_done_early", 32'(oDONE), 0);
        iCH_MASK = 3'b111;
        iSTART   = 1;
        tick();
        iSTART   = 0;
        chk("m0_done_pulse", 32'(oDONE), 1);
        chk("m0_busy_fall", 32'(oBUSY), 0);
        tick();
        chk("m0_done_once", 32'(oDONE), 0);
        chk("m0_restart_ignored", 32'(oBUSY), 0);
        repeat (5) tick();
        chk("m0_n_done", 32'(n_done), 1);
        chk("m0_done_latency", 32'(done_cyc - s), 2);
        chk("m0_n_writes", 32'(n_writes), 0);

        // Identity, all channels, vblank already high
        clr();
        push_ident(3'b111);
        start_load(MODE_IDENT, 3'b111, s);
        repeat (100) tick();
        chk("id_ready_low", 32'(oS_READY), 0);
        chk("id_busy", 32'(oBUSY), 1);
        wait_done(4000, "id");
        chk("id_n_writes", 32'(n_writes), 3072);
        chk("id_queue_empty", 32'(exp_addr.size()), 0);
        chk("id_first_latency", 32'(first_wr_cyc - s), 3);
        chk("id_span", 32'(last_wr_cyc - first_wr_cyc), 3071);
        chk("id_done_after_last", 32'(done_cyc - last_wr_cyc), 1);
        chk("id_done_latency", 32'(done_cyc - s), 3075);
        chk("id_lut_r_155", 32'(lut[0][10'h155]), 32'h155);
        chk("id_lut_b_3ff", 32'(lut[2][10'h3FF]), 32'h3FF);
        repeat (3) tick();
        chk("id_n_done", 32'(n_done), 1);
        chk("id_busy_fall", 32'(oBUSY), 0);

        // Stream into G only, host entries 1023-i with random stalls
        clr();
        for (int i = 0; i < N; i++) begin
            exp_addr.push_back({CH_G, DW'(i)});
            exp_data.push_back(DW'(N - 1 - i));
        end
        pend = 0;
        track_stream = 1;
        start_load(MODE_STREAM, 3'b010, s);
        k = 0;
        guard = 0;
        while (k < N && guard < 20000) begin
            iS_VALID = ($urandom_range(0, 2) != 0);
            iS_DATA  = DW'(N - 1 - k);
            if (oS_READY && iS_VALID) k++;
            tick();
            guard++;
        end
        iS_VALID = 0;
        chk("st_beats", 32'(k), N);
        wait_done(50, "st");
        track_stream = 0;
        chk("st_n_writes", 32'(n_writes), 1024);
        chk("st_queue_empty", 32'(exp_addr.size()), 0);
        chk("st_lut_g_0", 32'(lut[1][0]), 32'h3FF);
        chk("st_lut_g_3ff", 32'(lut[1][10'h3FF]), 0);
        chk("st_n_done", 32'(n_done), 1);

        // Start with vblank low: hold off for 50 cycles
        clr();
        iVBLANK = 0;
        push_ident(3'b001);
        start_load(MODE_IDENT, 3'b001, s);
        repeat (50) begin
            chk("vb_wait_busy", 32'(oBUSY), 1);
            chk("vb_wait_nowrite", 32'(oWRITE), 0);
            tick();
        end
        chk("vb_wait_writes", 32'(n_writes), 0);
        iVBLANK = 1;
        vb = cyc;
        wait_done(1100, "vb");
        chk("vb_first_latency", 32'(first_wr_cyc - vb), 2);
        chk("vb_n_writes", 32'(n_writes), 1024);
        chk("vb_queue_empty", 32'(exp_addr.size()), 0);

        // Abort while G index 500 is being issued
        clr();
        for (int i = 0; i < 500; i++) begin
            exp_addr.push_back({CH_G, DW'(i)});
            exp_data.push_back(DW'(i));
        end
        target = {CH_G, DW'(499)};
        start_load(MODE_IDENT, 3'b010, s);
        guard = 0;
        while (!(oWRITE && oWRADDRESS == target) && guard < 2000) begin
            tick();
            guard++;
        end
        chk("ab_reached_499", 32'(oWRADDRESS), 32'(target));
        iABORT = 1;
        tick();
        iABORT = 0;
        chk("ab_no_write", 32'(oWRITE), 0);
        chk("ab_code_zero", 32'(oWRADDRESS[DW+1:DW]), 0);
        chk("ab_busy_fall", 32'(oBUSY), 0);
        repeat (20) tick();
        chk("ab_no_done", 32'(n_done), 0);
        chk("ab_n_writes", 32'(n_writes), 500);
        chk("ab_queue_empty", 32'(exp_addr.size()), 0);

        // Reset mid-load, then a clean identity load of B
        clr();
        push_ident(3'b001);
        start_load(MODE_IDENT, 3'b001, s);
        guard = 0;
        while (n_writes < 100 && guard < 2000) begin
            tick();
            guard++;
        end
        chk("rst_reached_load", 32'(n_writes >= 100), 1);
        iRST = 1;
        tick();
        chk_all_zero("rst_mid");
        iRST = 0;
        tick();
        clr();
        push_ident(3'b100);
        start_load(MODE_IDENT, 3'b100, s);
        wait_done(1200, "rst_reload");
        chk("rst_n_writes", 32'(n_writes), 1024);
        chk("rst_queue_empty", 32'(exp_addr.size()), 0);
        chk("rst_lut_b_155", 32'(lut[2][10'h155]), 32'h155);
        chk("rst_n_done", 32'(n_done), 1);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/gamma_lut_ctrl.md
# gamma_lut_ctrl

Sequencer that loads the three per-channel gamma lookup RAMs (R, G, B) through their shared write port. It takes either a host-supplied stream of table entries or generates an identity ramp. Writes start only during vertical blanking, so the pixel path never reads a half-updated curve at frame start. It sits between the host/register block and the gamma correction stage, and drives its wrdata/wraddress/write inputs; wrclock is tied to iCLK.

## Interface
- DATA_WIDTH, 10, pixel/table-entry width; each table has 2^DATA_WIDTH entries
- iCLK  in  1  single clock for all logic
- iRST  in  1  synchronous, active-high reset
- iSTART  in  1  one-cycle load request; sampled only in IDLE
- iMODE  in  1  0 = stream load from host, 1 = identity fill (entry = index)
- iCH_MASK  in  3  channels to load: bit0 R, bit1 G, bit2 B
- iABORT  in  1  cancel an in-progress load
- iVBLANK  in  1  level, high during vertical blanking
- iS_DATA  in  DATA_WIDTH  host table entry
- iS_VALID  in  1  host entry valid
- oS_READY  out  1  controller accepts entry this cycle
- oWRDATA  out  DATA_WIDTH  LUT write data
- oWRADDRESS  out  DATA_WIDTH+2  {channel code[1:0], index}; code 1=R, 2=G, 3=B, 0=no write
- oWRITE  out  1  high when oWRADDRESS channel code is nonzero
- oBUSY  out  1  high in any state other than IDLE
- oDONE  out  1  one-cycle pulse on successful completion

## Operation
- The LUT decodes write enable from oWRADDRESS[DATA_WIDTH+1:DATA_WIDTH] alone. The channel code must be 0 on every cycle that is not a write. This is the primary safety rule.
- States: IDLE, WAIT_VB, LOAD, DONE.
- IDLE:
  - On iSTART, latch iMODE and iCH_MASK.
  - If the mask is 0, go to DONE.
  - Otherwise select the lowest set channel (R before G before B), clear the index, and go to WAIT_VB.
- WAIT_VB: stay until iVBLANK = 1, then go to LOAD.
  - If iVBLANK is already high on the cycle after start, LOAD begins then.
- LOAD, stream mode:
  - oS_READY = 1.
  - Each accepted beat (iS_VALID & oS_READY) writes iS_DATA to {code, index}, then increments the index.
  - Host stalls (iS_VALID = 0) insert no write and do not advance the index.
- LOAD, identity mode:
  - One write per cycle with data = index; oS_READY = 0.
- Index wrap: when a write lands at index 2^DATA_WIDTH-1, the index wraps to 0 and the next higher set channel is selected, staying in LOAD.
  - If no higher channel is set, go to DONE.
  - No vblank re-wait between channels; the load runs to completion once started.
- DONE: oDONE = 1 for one cycle, then return to IDLE.
- iABORT in WAIT_VB or LOAD returns to IDLE on the next cycle:
  - no further writes;
  - oDONE is not pulsed;
  - partially written tables are left as-is.
  - A beat accepted in the same cycle as iABORT is discarded.
- iABORT has priority over index-wrap and channel advance in the same cycle.
- iSTART while oBUSY = 1 is ignored. iABORT in IDLE is ignored.
- The channel code is a 2-bit value taken from the selected mask bit position + 1.

## Timing
- Reset values: state IDLE; oS_READY, oWRITE, oBUSY, oDONE = 0; oWRDATA = 0; oWRADDRESS = 0.
- All outputs are registered except oS_READY, which is decoded from state and mode.
- Write latency: a beat accepted at cycle n (or an identity index at cycle n) appears on oWRDATA/oWRADDRESS/oWRITE at cycle n+1, for exactly one cycle. The channel code returns to 0 at n+2 unless the next write follows.
- Identity throughput is 1 write/cycle: a full load takes 2^DATA_WIDTH × (channels set) cycles plus the vblank wait.
- oBUSY rises the cycle after iSTART and falls the cycle after DONE. It stays high until the last write has been presented on the outputs.
- oDONE asserts the cycle after the final write is presented.
- Reset mid-load: the next cycle is reset state, with the channel code forced to 0.

## Structure
- Shared package holds:
  - the channel-code constants (CH_NONE=0, CH_R=1, CH_G=2, CH_B=3);
  - the state enum;
  - the mode constants (MODE_STREAM, MODE_IDENT).
- Single module. A small combinational helper for "next set channel after current" may be a function; no sub-module is needed.
- Top-level integration places gamma_lut_ctrl beside the gamma stage and ties LUT wrclock to iCLK.

## Test plan
- Identity, mask 3'b111, iVBLANK high:
  - exactly 3072 writes: addresses 0x400–0x7FF, then 0x800–0xBFF, then 0xC00–0xFFF, with data = low 10 bits;
  - oDONE one pulse; gamma stage reads back iRed = 0x155 → 0x155.
- Stream, mask 3'b010, host drives entries 1023-i with random iS_VALID gaps:
  - 1024 writes to 0x800–0xBFF only, data = 1023-i;
  - no write on stall cycles; code 0 between writes.
- iSTART with iVBLANK low for 50 cycles:
  - zero writes and oBUSY = 1 during the wait;
  - the first write appears 2 cycles after iVBLANK rises.
- iABORT at index 500 of G in identity mode:
  - the last write is at most index 500;
  - code 0 from the next cycle; oDONE never asserts; oBUSY falls.
- Mask 3'b000: oDONE pulses 2 cycles after iSTART with no writes. A second iSTART while busy has no effect.
- iRST asserted mid-load: all outputs 0 the following cycle; a subsequent identity load completes normally.
